// File: rtl/count_pkg.sv
// count_pkg
// Shared widths, event type codes and the sample classifier used by
// count_event_queue.
//   CNT_W      : width of the upstream counter sample
//   EVT_W      : width of a queued event {type[1:0], value[3:0]}
//   evt_type_e : 00 none, 01 MATCH, 10 WRAP, 11 SKIP
package count_pkg;

  localparam int CNT_W = 4;
  localparam int EVT_W = 6;

  typedef enum logic [1:0] {
    EVT_NONE  = 2'b00,
    EVT_MATCH = 2'b01,
    EVT_WRAP  = 2'b10,
    EVT_SKIP  = 2'b11
  } evt_type_e;

  // Priority SKIP > WRAP > MATCH. A delta of 1 landing on 0 is the only
  // legal wrap; any other non-unit step (including an upstream reset to 0
  // from anything but 15) counts as a skip.
  function automatic evt_type_e classify(input logic [CNT_W-1:0] prev,
                                         input logic [CNT_W-1:0] cur,
                                         input logic [CNT_W-1:0] match);
    logic [CNT_W-1:0] delta;
    delta = cur - prev;
    if (delta == '0)                    return EVT_NONE;
    else if (delta != CNT_W'(1))        return EVT_SKIP;
    else if (cur == '0)                 return EVT_WRAP;
    else if (cur == match)              return EVT_MATCH;
    else                                return EVT_NONE;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
// Single-clock FIFO, DEPTH a power of two (2..16), synchronous active-high reset.
//   clk, rst        : clock, synchronous reset (clears pointers and occupancy)
//   push, din       : write request / data; accepted when not full or when a
//                     pop happens in the same cycle
//   pop             : read request; ignored while empty
//   dout            : head entry (valid while !empty)
//   full, empty     : occupancy flags
module sync_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             pop_eff, push_eff;

  assign empty    = (count_q == '0);
  assign full     = (count_q == FULL_CNT);
  assign pop_eff  = pop && !empty;
  assign push_eff = push && (!full || pop_eff);
  assign dout     = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_eff) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_eff)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_eff, pop_eff})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push_eff) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/count_event_queue.sv
// count_event_queue
// Watches samples of an upstream 4-bit counter, classifies each step as
// MATCH / WRAP / SKIP and queues the resulting events for a consumer.
//   clk, rst      : clock, synchronous active-high reset
//   cnt_in        : counter sample, qualified by cnt_valid
//   match_val     : match comparand, sampled with cnt_in
//   evt_valid     : FIFO head available on evt_data
//   evt_ready     : consumer accept (pop when evt_valid && evt_ready)
//   evt_data      : {type[1:0], value[3:0]}, 0 while evt_valid is low
//   wrap_count    : WRAP events accepted into the queue, modulo 256
//   overflow      : sticky, set when an event is dropped on a full queue
//   drop_count    : dropped events, saturating at 255
//                   (only with COUNT_EVENT_QUEUE_STATS_EN defined)
module count_event_queue
  import count_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] cnt_in,
  input  logic             cnt_valid,
  input  logic [CNT_W-1:0] match_val,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [EVT_W-1:0] evt_data,
  output logic [7:0]       wrap_count,
  output logic             overflow
`ifdef COUNT_EVENT_QUEUE_STATS_EN
  ,
  output logic [7:0]       drop_count
`endif
);

  logic             prev_ok_q, prev_ok_d;
  logic [CNT_W-1:0] prev_q, prev_d;
  logic [7:0]       wrap_q, wrap_d;
  logic             ovf_q, ovf_d;

  evt_type_e        evt_type;
  logic             evt_fire, fifo_push, fifo_pop, evt_drop;
  logic             fifo_full, fifo_empty;
  logic [EVT_W-1:0] fifo_dout;

  always_comb begin
    evt_type = EVT_NONE;
    if (cnt_valid && prev_ok_q) evt_type = classify(prev_q, cnt_in, match_val);
  end

  assign evt_fire  = (evt_type != EVT_NONE);
  assign fifo_pop  = !fifo_empty && evt_ready;
  // A full queue still takes the event when the head leaves in the same cycle.
  assign fifo_push = evt_fire && (!fifo_full || fifo_pop);
  assign evt_drop  = evt_fire && fifo_full && !fifo_pop;

  sync_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   ({evt_type, cnt_in}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign evt_valid  = !fifo_empty;
  assign evt_data   = fifo_empty ? '0 : fifo_dout;
  assign wrap_count = wrap_q;
  assign overflow   = ovf_q;

  always_comb begin
    prev_ok_d = prev_ok_q;
    prev_d    = prev_q;
    wrap_d    = wrap_q;
    ovf_d     = ovf_q;
    if (cnt_valid) begin
      prev_ok_d = 1'b1;
      prev_d    = cnt_in;
    end
    if (fifo_push && evt_type == EVT_WRAP) wrap_d = wrap_q + 8'd1;
    if (evt_drop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_ok_q <= 1'b0;
      prev_q    <= '0;
      wrap_q    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      prev_ok_q <= prev_ok_d;
      prev_q    <= prev_d;
      wrap_q    <= wrap_d;
      ovf_q     <= ovf_d;
    end
  end

`ifdef COUNT_EVENT_QUEUE_STATS_EN
  logic [7:0] drop_q, drop_d;

  always_comb begin
    drop_d = drop_q;
    if (evt_drop && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) drop_q <= '0;
    else     drop_q <= drop_d;
  end

  assign drop_count = drop_q;
`endif

endmodule

// File: tb/tb_count_event_queue.sv
module tb_count_event_queue;
  import count_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] cnt_in = '0;
  logic       cnt_valid = 1'b0;
  logic [3:0] match_val = '0;
  logic       evt_valid;
  logic       evt_ready = 1'b1;
  logic [5:0] evt_data;
  logic [7:0] wrap_count;
  logic       overflow;
`ifdef COUNT_EVENT_QUEUE_STATS_EN
  logic [7:0] drop_count;
`endif

  int total = 0;
  int bad   = 0;
  logic [5:0] exp_q[$];

  always #5 clk = ~clk;

  count_event_queue #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .cnt_in     (cnt_in),
    .cnt_valid  (cnt_valid),
    .match_val  (match_val),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_data   (evt_data),
    .wrap_count (wrap_count),
    .overflow   (overflow)
`ifdef COUNT_EVENT_QUEUE_STATS_EN
    ,
    .drop_count (drop_count)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every handshake pops the next expected event.
  initial begin
    logic [5:0] e;
    forever begin
      @(negedge clk);
      if (evt_valid && evt_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_evt got=%0h expected=none at %0t", evt_data, $time);
        end else begin
          e = exp_q.pop_front();
          chk("evt_order", {26'd0, evt_data}, {26'd0, e});
        end
      end
    end
  end

  function automatic logic [5:0] ev(input logic [1:0] t, input logic [3:0] v);
    return {t, v};
  endfunction

  // Drive a sample at posedge+1; returns at posedge+1 after the sampling edge.
  task automatic sample(input logic [3:0] c, input logic [3:0] m);
    cnt_in    = c;
    match_val = m;
    cnt_valid = 1'b1;
    @(posedge clk); #1;
    cnt_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    cnt_valid = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic drain(input string name);
    evt_ready = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk(name, exp_q.size(), 0);
  endtask

  // Table of samples continuing after 7,7,0: {cnt, match, has_event, event}
  typedef struct packed {
    logic [3:0] c;
    logic [3:0] m;
    logic       has;
    logic [5:0] e;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{c: 4'd2,  m: 4'd2, has: 1'b1, e: 6'h32}; // skip beats match
    vecs[1] = '{c: 4'd3,  m: 4'd3, has: 1'b1, e: 6'h13}; // match
    vecs[2] = '{c: 4'd4,  m: 4'd9, has: 1'b0, e: 6'h00}; // plain step
    vecs[3] = '{c: 4'd15, m: 4'd0, has: 1'b1, e: 6'h3F}; // skip
    vecs[4] = '{c: 4'd0,  m: 4'd0, has: 1'b1, e: 6'h20}; // wrap beats match

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", evt_valid, 0);
    chk("rst_data", evt_data, 0);
    chk("rst_wrap", wrap_count, 0);
    chk("rst_ovf", overflow, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_valid", evt_valid, 0);
    chk("post_rst_data", evt_data, 0);

    // 14,15,0,1 match 9 -> single WRAP(0)
    evt_ready = 1'b1;
    sample(4'd14, 4'd9);
    chk("first_sample_no_evt", evt_valid, 0);
    sample(4'd15, 4'd9);
    chk("step_no_evt", evt_valid, 0);
    exp_q.push_back(ev(EVT_WRAP, 4'd0));
    sample(4'd0, 4'd9);
    chk("wrap_latency_valid", evt_valid, 1);
    chk("wrap_latency_data", evt_data, 6'h20);
    sample(4'd1, 4'd9);
    chk("wrap_count_1", wrap_count, 1);

    // 3,4,5 match 5 -> MATCH(5) one cycle after third sample
    do_reset();
    sample(4'd3, 4'd5);
    sample(4'd4, 4'd5);
    chk("match_not_early", evt_valid, 0);
    exp_q.push_back(ev(EVT_MATCH, 4'd5));
    sample(4'd5, 4'd5);
    chk("match_latency_valid", evt_valid, 1);
    chk("match_latency_data", evt_data, 6'h15);
    @(posedge clk); #1;

    // 7,7,0 -> SKIP(0) only; then a priority table
    do_reset();
    sample(4'd7, 4'd0);
    sample(4'd7, 4'd7);
    chk("repeat_no_evt", evt_valid, 0);
    exp_q.push_back(ev(EVT_SKIP, 4'd0));
    sample(4'd0, 4'd9);
    chk("skip_latency_data", evt_data, 6'h30);
    chk("skip_wrap_count", wrap_count, 0);
    foreach (vecs[i]) begin
      if (vecs[i].has) exp_q.push_back(vecs[i].e);
      sample(vecs[i].c, vecs[i].m);
      chk("table_valid", evt_valid, {31'd0, vecs[i].has});
    end
    chk("table_wrap_count", wrap_count, 1);
    drain("table_drain");

    // Overflow: ready low, 5 SKIPs into DEPTH 4
    do_reset();
    evt_ready = 1'b0;
    sample(4'd0, 4'd15);
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_q.push_back(ev(EVT_SKIP, 4'(2 * i)));
      sample(4'(2 * i), 4'd15);
    end
    chk("ovf_set", overflow, 1);
    chk("ovf_head_stable", evt_data, 6'h32);
`ifdef COUNT_EVENT_QUEUE_STATS_EN
    chk("drop_count_1", drop_count, 1);
`endif
    drain("ovf_drain");
    chk("ovf_sticky", overflow, 1);

    // Full + event + pop in the same cycle -> accepted
    do_reset();
    evt_ready = 1'b0;
    sample(4'd0, 4'd15);
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(ev(EVT_SKIP, 4'(2 * i)));
      sample(4'(2 * i), 4'd15);
    end
    chk("full_no_ovf", overflow, 0);
    exp_q.push_back(ev(EVT_SKIP, 4'd10));
    evt_ready = 1'b1;
    sample(4'd10, 4'd15);
    evt_ready = 1'b0;
    chk("full_pop_no_ovf", overflow, 0);
    sample(4'd12, 4'd15); // queue still holds 4, so this one drops
    chk("still_full_drop", overflow, 1);
    drain("full_pop_drain");

    // Reset mid-operation with 3 queued, reset beats a simultaneous sample
    do_reset();
    evt_ready = 1'b0;
    sample(4'd0, 4'd15);
    sample(4'd2, 4'd15);
    sample(4'd4, 4'd15);
    sample(4'd6, 4'd15);
    chk("three_queued", evt_valid, 1);
    rst       = 1'b1;
    cnt_in    = 4'd12;
    cnt_valid = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst       = 1'b0;
    cnt_valid = 1'b0;
    chk("rst_flush_valid", evt_valid, 0);
    chk("rst_flush_ovf", overflow, 0);
    evt_ready = 1'b1;
    sample(4'd9, 4'd9);
    chk("after_rst_prev_only", evt_valid, 0);
    exp_q.push_back(ev(EVT_MATCH, 4'd10));
    sample(4'd10, 4'd10);
    chk("after_rst_match", evt_data, 6'h1A);
    drain("final_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
